regfile_bus_ctrl: RTL and testbench



---
 rtl/regfile_bus_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_regfile_bus_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bus_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_bus_ctrl
//
// Clocked bus master for an asynchronous-strobe register file. A single-cycle
// request (REQ/WR/ADDR_IN/WDATA) accepted while idle is turned into the
// register file's pin sequence: active-low chip select, output enable,
// rising-edge write strobe and a shared tri-state data bus. Read data and a
// one-cycle completion pulse come back to the clocked core.
//
// Optional feature (macro REGFILE_BUS_CTRL_VERIFY_EN):
//   every write is followed by an automatic read-back. The read-back word is
//   returned on RDATA and compared with the written word; VERIFY_ERR reports
//   a difference on the ACK cycle and clears on the next accepted command.
//
// Parameters:
//   WIDTH   - data bus width in bits
//   DEPTH   - address width in bits (2**DEPTH words)
//   RD_WAIT - cycles (>=1) DATA may settle after OE/CS assert before capture
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous active-high reset
//   REQ        in   command valid, sampled only while idle
//   WR         in   command type: 1 = write, 0 = read
//   ADDR_IN    in   command address, latched on acceptance
//   WDATA      in   write data, latched on acceptance
//   BUSY       out  high from the cycle after acceptance through the ACK cycle
//   ACK        out  one-cycle completion pulse
//   RDATA      out  last captured read word
//   DATA       io   shared register file data bus
//   ADDR       out  register file address (holds while idle)
//   OE         out  register file output enable (1 = read)
//   CS         out  register file chip select, active low
//   WS         out  register file write strobe
//   VERIFY_ERR out  read-back mismatch flag (only with the macro defined)
//
// Every pin output is a flop; the bus driver enable is a flop as well, so
// there is no combinational path from the request inputs to the pins.
// -----------------------------------------------------------------------------
module regfile_bus_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 5,
  parameter int RD_WAIT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ,
  input  logic             WR,
  input  logic [DEPTH-1:0] ADDR_IN,
  input  logic [WIDTH-1:0] WDATA,
  output logic             BUSY,
  output logic             ACK,
  output logic [WIDTH-1:0] RDATA,
  inout  wire  [WIDTH-1:0] DATA,
  output logic [DEPTH-1:0] ADDR,
  output logic             OE,
  output logic             CS,
  output logic             WS
`ifdef REGFILE_BUS_CTRL_VERIFY_EN
  ,
  output logic             VERIFY_ERR
`endif
);

  // Counter only has to reach RD_WAIT-1.
  localparam int CNT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_STROBE = 3'd2,
    W_HOLD   = 3'd3,
    R_TURN   = 3'd4,
    R_WAIT   = 3'd5,
    R_CAP    = 3'd6,
    DONE     = 3'd7
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   wdata_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               drive_r;   // controller owns DATA this cycle
`ifdef REGFILE_BUS_CTRL_VERIFY_EN
  logic               wr_r;      // current command is a write (selects compare)
`endif

  // Bus driver: only the registered enable decides who owns DATA.
  assign DATA = drive_r ? wdata_r : {WIDTH{1'bz}};

  // Command FSM; pin values are registered alongside the state they belong to.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r    <= IDLE;
      wdata_r    <= {WIDTH{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      drive_r    <= 1'b0;
      BUSY       <= 1'b0;
      ACK        <= 1'b0;
      RDATA      <= {WIDTH{1'b0}};
      ADDR       <= {DEPTH{1'b0}};
      OE         <= 1'b0;
      CS         <= 1'b1;
      WS         <= 1'b0;
`ifdef REGFILE_BUS_CTRL_VERIFY_EN
      wr_r       <= 1'b0;
      VERIFY_ERR <= 1'b0;
`endif
    end else begin
      // ACK is a single-cycle pulse unless the completing transition sets it.
      ACK <= 1'b0;
      case (state_r)
        IDLE: begin
          if (REQ) begin
            wdata_r <= WDATA;
            ADDR    <= ADDR_IN;
            BUSY    <= 1'b1;
`ifdef REGFILE_BUS_CTRL_VERIFY_EN
            wr_r       <= WR;
            VERIFY_ERR <= 1'b0;
`endif
            if (WR) begin
              // Address, data and select all settle a full cycle ahead of WS.
              state_r <= W_SETUP;
              CS      <= 1'b0;
              drive_r <= 1'b1;
            end else begin
              // Pins already idle; R_TURN just keeps the bus released.
              state_r <= R_TURN;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        W_SETUP: begin
          state_r <= W_STROBE;
          WS      <= 1'b1;
        end

        W_STROBE: begin
          state_r <= W_HOLD;
          WS      <= 1'b0;
        end

        W_HOLD: begin
          // Leaving hold: release the bus and deselect in the same edge.
          CS      <= 1'b1;
          drive_r <= 1'b0;
`ifdef REGFILE_BUS_CTRL_VERIFY_EN
          state_r <= R_TURN;
`else
          state_r <= DONE;
          ACK     <= 1'b1;
`endif
        end

        R_TURN: begin
          // One full released cycle has passed; let the register file drive.
          state_r <= R_WAIT;
          CS      <= 1'b0;
          OE      <= 1'b1;
          cnt_r   <= {CNT_W{1'b0}};
        end

        R_WAIT: begin
          if (cnt_r == CNT_W'(RD_WAIT - 1)) begin
            state_r <= R_CAP;
          end else begin
            state_r <= R_WAIT;
            cnt_r   <= cnt_r + CNT_W'(1);
          end
        end

        R_CAP: begin
          RDATA   <= DATA;
`ifdef REGFILE_BUS_CTRL_VERIFY_EN
          if (wr_r) begin
            VERIFY_ERR <= (DATA != wdata_r);
          end else begin
            VERIFY_ERR <= 1'b0;
          end
`endif
          state_r <= DONE;
          CS      <= 1'b1;
          OE      <= 1'b0;
          ACK     <= 1'b1;
        end

        DONE: begin
          state_r <= IDLE;
          BUSY    <= 1'b0;
        end

        default: begin
          // Unreachable encoding: fall back to safe idle pins.
          state_r <= IDLE;
          drive_r <= 1'b0;
          BUSY    <= 1'b0;
          OE      <= 1'b0;
          CS      <= 1'b1;
          WS      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_bus_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for regfile_bus_ctrl with a behavioural register file
// on the shared bus and a reference memory model predicting read data,
// latencies and the read-back flag.
module tb_regfile_bus_ctrl;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 5;
  localparam int RD_WAIT = 1;
`ifdef REGFILE_BUS_CTRL_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int WR_LAT = VERIFY ? (6 + RD_WAIT) : 4;
  localparam int RD_LAT = 3 + RD_WAIT;

  logic             clk = 1'b0;
  logic             rst;
  logic             req;
  logic             wr;
  logic [DEPTH-1:0] addr_in;
  logic [WIDTH-1:0] wdata;
  logic             busy, ack, oe, cs, ws;
  logic [WIDTH-1:0] rdata;
  logic [DEPTH-1:0] addr;
  wire  [WIDTH-1:0] data_bus;
`ifdef REGFILE_BUS_CTRL_VERIFY_EN
  logic             verify_err;
`endif

  regfile_bus_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_WAIT(RD_WAIT)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .WR(wr), .ADDR_IN(addr_in), .WDATA(wdata),
    .BUSY(busy), .ACK(ack), .RDATA(rdata), .DATA(data_bus), .ADDR(addr),
    .OE(oe), .CS(cs), .WS(ws)
`ifdef REGFILE_BUS_CTRL_VERIFY_EN
    , .VERIFY_ERR(verify_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural register file: writes on WS rising edge, drives when selected.
  logic [WIDTH-1:0] rf_mem [32];
  logic             stuck9 = 1'b0;
  logic [WIDTH-1:0] rf_rd;
  assign rf_rd    = (stuck9 && addr == 5'd9) ? 8'h00 : rf_mem[addr];
  assign data_bus = (!cs && oe) ? rf_rd : 8'bzzzzzzzz;
  always @(posedge ws) if (!cs && !oe) rf_mem[addr] <= data_bus;

  // Reference model state.
  logic [WIDTH-1:0] ref_mem [32];
  logic [WIDTH-1:0] ref_rdata = 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pin-protocol monitor: bus contention, strobe qualification, pulse widths.
  logic prev_drive = 1'b0, prev_ws = 1'b0, prev_ack = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      check_val("drive_while_oe", dut.drive_r & oe, 32'd0);
      check_val("oe_after_drive", prev_drive & oe, 32'd0);
      check_val("ws_qualified", ws & (cs | oe), 32'd0);
      check_val("ws_one_cycle", ws & prev_ws, 32'd0);
      check_val("ack_one_cycle", ack & prev_ack, 32'd0);
    end
    prev_drive <= dut.drive_r;
    prev_ws    <= ws;
    prev_ack   <= ack;
  end

  // One complete command, checked end to end against the reference model.
  task automatic do_cmd(input logic w, input logic [DEPTH-1:0] a, input logic [WIDTH-1:0] d);
    int   start;
    int   ws_seen;
    logic got_ack;
    logic [WIDTH-1:0] exp_rd;
    @(negedge clk);
    for (int k = 0; k < 50 && busy; k++) @(negedge clk);
    check_val("idle_before_cmd", busy, 32'd0);
    req = 1'b1; wr = w; addr_in = a; wdata = d;
    start = cyc; ws_seen = 0; got_ack = 1'b0; exp_rd = 8'h00;
    for (int i = 1; i <= 40 && !got_ack; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req = 1'b0;
        check_val("busy_after_accept", busy, 32'd1);
        check_val("addr_pin", addr, a);
      end
      if (ws) begin
        ws_seen++;
        check_val("ws_data", data_bus, d);
        check_val("ws_offset", cyc - start, 32'd2);
      end
      if (ack) got_ack = 1'b1;
    end
    check_val("ack_seen", got_ack, 32'd1);
    if (got_ack) begin
      if (w) begin
        check_val("wr_latency", cyc - start, WR_LAT);
        check_val("ws_count_wr", ws_seen, 32'd1);
      end else begin
        check_val("rd_latency", cyc - start, RD_LAT);
        check_val("ws_count_rd", ws_seen, 32'd0);
      end
      check_val("busy_at_ack", busy, 32'd1);
      if (w) ref_mem[a] = d;
      if (!w || VERIFY) begin
        exp_rd    = (stuck9 && a == 5'd9) ? 8'h00 : ref_mem[a];
        ref_rdata = exp_rd;
      end
      check_val("rdata", rdata, ref_rdata);
`ifdef REGFILE_BUS_CTRL_VERIFY_EN
      check_val("verify_err", verify_err, (w && exp_rd != d) ? 32'd1 : 32'd0);
`endif
      @(negedge clk);
      check_val("busy_after_ack", busy, 32'd0);
      check_val("ack_after_ack", ack, 32'd0);
    end
  endtask

  initial begin
    int n_ack, n_acc, last_ack, seen;
    rst = 1'b1; req = 1'b0; wr = 1'b0; addr_in = 5'd0; wdata = 8'h00;
    #1;
    check_val("rst_cs", cs, 32'd1);
    check_val("rst_oe", oe, 32'd0);
    check_val("rst_ws", ws, 32'd0);
    check_val("rst_drive", dut.drive_r, 32'd0);
    check_val("rst_addr", addr, 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    check_val("rst_ack", ack, 32'd0);
    check_val("rst_busy", busy, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Preload every word so all later reads have a known expectation.
    for (int i = 0; i < 32; i++) do_cmd(1'b1, 5'(i), 8'($urandom));

    // Basic write then read-back.
    do_cmd(1'b1, 5'd3, 8'hA5);
    do_cmd(1'b0, 5'd3, 8'h00);

    // Boundary addresses.
    do_cmd(1'b1, 5'd0, 8'h01);
    do_cmd(1'b1, 5'd31, 8'hFE);
    do_cmd(1'b0, 5'd0, 8'h00);
    do_cmd(1'b0, 5'd31, 8'h00);

    // Back-to-back reads of 5,6,7 with REQ held high and noise while busy.
    @(negedge clk);
    for (int k = 0; k < 50 && busy; k++) @(negedge clk);
    n_ack = 0; n_acc = 0; last_ack = 0;
    wr = 1'b0;
    for (int i = 0; i < 80 && n_ack < 3; i++) begin
      if (ack) begin
        check_val("b2b_rdata", rdata, ref_mem[5 + n_ack]);
        if (n_ack > 0) check_val("b2b_spacing", cyc - last_ack, 4 + RD_WAIT);
        last_ack = cyc;
        n_ack++;
      end
      if (!busy) begin
        req     = (n_acc < 3);
        addr_in = 5'(5 + n_acc);
        if (n_acc < 3) n_acc++;
      end else begin
        req     = 1'($urandom_range(0, 1));
        addr_in = 5'($urandom_range(0, 31));
      end
      if (n_ack < 3) @(negedge clk);
    end
    req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ack) n_ack++;
    end
    check_val("b2b_ack_count", n_ack, 32'd3);
    ref_rdata = ref_mem[7];

    // Random command mix under the contention monitor.
    for (int k = 0; k < 200; k++)
      do_cmd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom));

    // Reset in the middle of the write strobe.
    @(negedge clk);
    for (int k = 0; k < 50 && busy; k++) @(negedge clk);
    req = 1'b1; wr = 1'b1; addr_in = 5'd20; wdata = 8'h5A;
    @(negedge clk);
    req = 1'b0;
    for (int k = 0; k < 10 && !ws; k++) @(negedge clk);
    check_val("strobe_reached", ws, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("abort_cs", cs, 32'd1);
    check_val("abort_ws", ws, 32'd0);
    check_val("abort_oe", oe, 32'd0);
    check_val("abort_drive", dut.drive_r, 32'd0);
    check_val("abort_busy", busy, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack || busy) seen++;
    end
    check_val("no_ack_after_abort", seen, 32'd0);
    check_val("rdata_after_abort", rdata, 32'd0);
    ref_rdata   = 8'h00;
    ref_mem[20] = rf_mem[20];
    do_cmd(1'b0, 5'd20, 8'h00);

`ifdef REGFILE_BUS_CTRL_VERIFY_EN
    // Stuck word at address 9: the read-back must expose the failed write.
    stuck9 = 1'b1;
    do_cmd(1'b1, 5'd9, 8'h3C);
    do_cmd(1'b1, 5'd9, 8'h00);
    stuck9 = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
